// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: 1-to-N stream demultiplexer with unicast/broadcast routing and per-channel output registers.
module demux_1xn_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               bcast,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               drop_pulse,
  output logic [7:0]         drop_cnt
);
  logic [N-1:0]       valid_q, valid_d, free, hit, wr;
  logic [N*WIDTH-1:0] data_q, data_d;
  logic               acc, drop, drop_pulse_q;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  // An out-of-range unicast select hits no channel, so it is always ready and becomes a drop.
  always_comb begin
    free = ~valid_q | out_ready;
    for (int k = 0; k < N; k++) hit[k] = bcast | (in_sel == SELW'(k));
    in_ready = !rst && (bcast ? &free : (!(|hit) || |(hit & free)));
    acc = in_valid && in_ready;
    wr = acc ? hit : '0;
    drop = acc && !bcast && !(|hit);
    valid_d = valid_q;
    data_d = data_q;
    for (int k = 0; k < N; k++) begin
      if (wr[k]) begin
        valid_d[k] = 1'b1;
        data_d[k*WIDTH +: WIDTH] = in_data;
      end else if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
        data_d[k*WIDTH +: WIDTH] = '0;
      end
    end
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      data_q       <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      drop_pulse_q <= drop;
      drop_cnt_q   <= drop_cnt_d;
    end
  end
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_demux_1xn_stream.sv
// tb_demux_1xn_stream: directed and random checks of demux_1xn_stream against a behavioural model.
module tb_demux_1xn_stream;
  localparam int W = 8, N = 4, SW = 3;
  logic clk = 0, rst = 1, in_valid = 0, bcast = 0, in_ready, drop_pulse;
  logic [W-1:0] in_data = 0;
  logic [SW-1:0] in_sel = 0;
  logic [N-1:0] out_valid, out_ready = 0;
  logic [N*W-1:0] out_data;
  logic [7:0] drop_cnt;
  int n_cmp = 0, n_err = 0;
  bit armed = 0;
  bit mv[N];
  int md[N];
  bit mpulse;
  int mcnt;

  demux_1xn_stream #(.WIDTH(W), .N(N), .SELW(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .bcast(bcast), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    bit all_free = 1;
    if (rst) return 0;
    for (int k = 0; k < N; k++) if (mv[k] && !out_ready[k]) all_free = 0;
    if (bcast) return all_free;
    if (int'(in_sel) >= N) return 1;
    return !mv[in_sel] || out_ready[in_sel];
  endfunction

  always @(posedge clk) begin
    bit acc;
    acc = in_valid && model_ready();
    if (rst) begin
      for (int k = 0; k < N; k++) begin mv[k] = 0; md[k] = 0; end
      mpulse = 0; mcnt = 0; armed = 1;
    end else begin
      for (int k = 0; k < N; k++)
        if (acc && (bcast || int'(in_sel) == k)) begin mv[k] = 1; md[k] = in_data; end
        else if (mv[k] && out_ready[k]) begin mv[k] = 0; md[k] = 0; end
      mpulse = acc && !bcast && int'(in_sel) >= N;
      if (mpulse && mcnt < 255) mcnt++;
    end
  end

  always @(negedge clk) if (armed) begin
    logic [N-1:0] ev;
    logic [N*W-1:0] ed;
    for (int k = 0; k < N; k++) begin ev[k] = mv[k]; ed[k*W +: W] = W'(md[k]); end
    chk("m_out_valid", 64'(out_valid), 64'(ev));
    chk("m_out_data", 64'(out_data), 64'(ed));
    chk("m_in_ready", 64'(in_ready), 64'(model_ready()));
    chk("m_drop_pulse", 64'(drop_pulse), 64'(mpulse));
    chk("m_drop_cnt", 64'(drop_cnt), 64'(mcnt));
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    cyc(2);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_drop_cnt", 64'(drop_cnt), 0);
    rst = 0; out_ready = 4'hF; in_sel = 2; in_valid = 1; in_data = 8'h11;
    cyc(); in_data = 8'h22;
    chk("uni_v1", 64'(out_valid), 64'h4); chk("uni_d1", 64'(out_data[2*W +: W]), 64'h11);
    cyc(); in_data = 8'h33;
    chk("uni_v2", 64'(out_valid), 64'h4); chk("uni_d2", 64'(out_data[2*W +: W]), 64'h22);
    cyc(); in_valid = 0;
    chk("uni_v3", 64'(out_valid), 64'h4); chk("uni_d3", 64'(out_data[2*W +: W]), 64'h33);
    cyc();
    chk("uni_empty", 64'(out_valid), 0);
    out_ready = 0; in_sel = 1; in_valid = 1; in_data = 8'hA5;
    cyc(); in_data = 8'hB6; #1;
    chk("bp_ready0", 64'(in_ready), 0);
    cyc();
    chk("bp_hold", 64'(out_data[W +: W]), 64'hA5); chk("bp_hold_v", 64'(out_valid), 64'h2);
    out_ready[1] = 1; #1;
    chk("bp_ready1", 64'(in_ready), 1);
    cyc(); in_valid = 0;
    chk("bp_new", 64'(out_data[W +: W]), 64'hB6);
    cyc();
    out_ready = 4'b1011; in_sel = 2; in_valid = 1; in_data = 8'h77;
    cyc(); bcast = 1; in_data = 8'h5A; #1;
    chk("bc_ready0", 64'(in_ready), 0);
    cyc();
    chk("bc_hold", 64'(out_data[2*W +: W]), 64'h77);
    out_ready = 4'hF; #1;
    chk("bc_ready1", 64'(in_ready), 1);
    cyc(); in_valid = 0; bcast = 0;
    chk("bc_valid", 64'(out_valid), 64'hF); chk("bc_data", 64'(out_data), 64'h5A5A5A5A);
    cyc();
    in_sel = 5; in_valid = 1; #1;
    chk("drop_ready", 64'(in_ready), 1);
    cyc(); in_valid = 0;
    chk("drop_pulse1", 64'(drop_pulse), 1); chk("drop_cnt1", 64'(drop_cnt), 1);
    chk("drop_nov", 64'(out_valid), 0);
    cyc();
    chk("drop_pulse0", 64'(drop_pulse), 0);
    in_valid = 1; cyc(299); in_valid = 0; cyc();
    chk("drop_sat", 64'(drop_cnt), 255);
    out_ready = 0; in_valid = 1; in_sel = 0; in_data = 8'h01;
    cyc(); in_sel = 3; in_data = 8'h03;
    cyc(); in_valid = 0;
    chk("rm_valid", 64'(out_valid), 64'h9);
    rst = 1; #1;
    chk("rm_ready", 64'(in_ready), 0);
    cyc(); rst = 0;
    chk("rm_v0", 64'(out_valid), 0); chk("rm_d0", 64'(out_data), 0); chk("rm_cnt0", 64'(drop_cnt), 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_sel = SW'($urandom_range(0, 5));
      bcast = $urandom_range(0, 7) == 0;
      in_data = W'($urandom);
      out_ready = N'($urandom) | N'($urandom);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
